vending_controller_param: RTL and testbench
===========================================

VENDING_CONTROLLER_PARAM -- requirements
Module: vending_controller_param

Interface
REQ-001 SHALL have parameter NUM_PROD, default 4: number of products, 2..16.
REQ-002 SHALL have parameter PSEL_W, default 2: product-select width, equal to clog2(NUM_PROD).
REQ-003 SHALL have parameter CREDIT_W, default 5: credit, price and change width.
REQ-004 SHALL have parameter PRICE_LIST, default 20'hA3D45: flattened prices; product i at [i*CREDIT_W +: CREDIT_W]; defaults are 5, 10, 15, 20 for products 0..3.
REQ-005 SHALL have parameter STOCK_INIT, default 3: initial stock per product (macro build only).
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-008 SHALL have port enable, input, 1 bit: accepts coin_insert, coin_return and vend_req when high.
REQ-009 SHALL have port coin, input, 2 bits: coin type; 00=1, 01=2, 10=5, 11=10 units.
REQ-010 SHALL have port coin_insert, input, 1 bit: one-cycle strobe, one coin per cycle.
REQ-011 SHALL have port coin_return, input, 1 bit: refund request strobe.
REQ-012 SHALL have port product, input, PSEL_W bits: selected product.
REQ-013 SHALL have port vend_req, input, 1 bit: purchase request strobe.
REQ-014 SHALL have port pro, output, PSEL_W bits: dispensed product, valid with pro_valid.
REQ-015 SHALL have port pro_valid, output, 1 bit: one-cycle dispense pulse.
REQ-016 SHALL have port change, output, CREDIT_W bits: change amount, valid with change_valid; otherwise 0.
REQ-017 SHALL have port change_valid, output, 1 bit: one-cycle change pulse.
REQ-018 SHALL have port credit, output, CREDIT_W bits: current accumulated credit.
REQ-019 SHALL have port reject, output, 1 bit: one-cycle pulse on a refused coin or vend request.
REQ-020 SHALL have port busy, output, 1 bit: high in the VEND and CHANGE states.

Function
REQ-021 SHALL implement the states IDLE, COLLECT, VEND and CHANGE.
REQ-022 IDLE: credit is 0; an accepted coin_insert SHALL add the coin value and go to COLLECT next cycle.
REQ-023 COLLECT: coin_insert SHALL add the coin value; if the sum exceeds 2^CREDIT_W-1, the coin is refused, reject pulses and credit is unchanged.
REQ-024 COLLECT: vend_req SHALL go to VEND when product < NUM_PROD and credit >= the price (and stock > 0 under the macro); it SHALL latch the product; otherwise reject pulses and the state and credit hold.
REQ-025 COLLECT: coin_return SHALL go to CHANGE.
REQ-026 Same-cycle priority in COLLECT SHALL be coin_return, then vend_req, then coin_insert; lower-priority strobes are dropped without reject.
REQ-027 VEND lasts one cycle: pro_valid=1, pro=latched product, and credit is reduced by the price at its end; next state is CHANGE if the remainder > 0, else IDLE.
REQ-028 CHANGE lasts one cycle: change_valid=1, change=credit, credit becomes 0, and the next state is IDLE.
REQ-029 Latency SHALL be fixed: vend_req sampled at edge N gives pro_valid in cycle N+1 and change_valid in cycle N+2; coin_return at N gives change_valid in cycle N+1.
REQ-030 With enable low, strobes SHALL be ignored and produce no reject; VEND and CHANGE still complete.
REQ-031 coin_insert, coin_return and vend_req arriving while busy SHALL be ignored.
REQ-032 vend_req and coin_return in IDLE SHALL be ignored.

Reset
REQ-033 On reset: state=IDLE, credit=0, pro=0, pro_valid=0, change=0, change_valid=0, reject=0, busy=0, and every stock counter = STOCK_INIT.
REQ-034 Reset mid-operation SHALL discard credit with no change pulse and SHALL override all strobes in the same cycle.

Configuration
REQ-035 Macro VEND_STOCK_EN defined: per-product stock counters of clog2(STOCK_INIT+1) bits, decremented in VEND, with vend refused at 0.
REQ-036 Macro VEND_STOCK_EN defined: adds output sold_out, NUM_PROD bits, where bit i is high when stock i = 0, reset value 0 unless STOCK_INIT = 0.
REQ-037 Macro VEND_STOCK_EN undefined: no counters, no sold_out port, and stock never limits vending.

Verification
REQ-038 Coin 11, then vend_req with product=1 -> pro=1 with pro_valid next cycle; no change_valid; credit=0.
REQ-039 Coins 11 and 10 (credit 15), vend_req with product=0 -> pro=0, then change=10 with change_valid the following cycle.
REQ-040 Coin 01 (credit 2), vend_req with product=3 -> reject pulse, credit=2; then coin_return -> change=2 next cycle.
REQ-041 Coins 11, 11, 11 (credit 30), then coin 01 -> reject, credit=30; coin_return and vend_req with product=0 in the same cycle -> change=30, no pro_valid.
REQ-042 VEND_STOCK_EN: three purchases of product 0 -> sold_out[0]=1; a fourth vend_req with credit 5 -> reject, credit=5.
REQ-043 Reset asserted in COLLECT with credit 7 -> next cycle credit=0, IDLE, no change_valid.

Source files
------------

// File: rtl/vending_controller_param.sv
// Coin-operated vending controller: IDLE/COLLECT/VEND/CHANGE with per-product prices.
// Optional per-product stock counting and sold_out output when VEND_STOCK_EN is defined.
`ifdef VEND_STOCK_EN
module vend_stock_cnt #(
  parameter int W    = 2,
  parameter int INIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic dec,
  output logic empty
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)                    cnt_q <= W'(INIT);
    else if (dec && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign empty = (cnt_q == '0);
endmodule
`endif

module vending_controller_param #(
  parameter int NUM_PROD = 4,
  parameter int PSEL_W   = 2,
  parameter int CREDIT_W = 5,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICE_LIST = 20'hA3D45,
  parameter int STOCK_INIT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          coin,
  input  logic                coin_insert,
  input  logic                coin_return,
  input  logic [PSEL_W-1:0]   product,
  input  logic                vend_req,
  output logic [PSEL_W-1:0]   pro,
  output logic                pro_valid,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] credit,
  output logic                reject,
  output logic                busy
`ifdef VEND_STOCK_EN
  ,
  output logic [NUM_PROD-1:0] sold_out
`endif
);
  if (NUM_PROD < 2 || NUM_PROD > 16 || PSEL_W != $clog2(NUM_PROD) || STOCK_INIT < 0) begin : g_param_check
    $error("vending_controller_param: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [PSEL_W-1:0]   prod_q, prod_d;
  logic                reject_q, reject_d;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] sel_price, vend_price;
  logic                prod_ok, stock_ok, vend_ok;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [PSEL_W-1:0] p);
    price_of = '0;
    for (int i = 0; i < NUM_PROD; i++)
      if (p == PSEL_W'(i)) price_of = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
  endfunction

  function automatic logic [CREDIT_W:0] coin_val(input logic [1:0] c);
    case (c)
      2'b00:   coin_val = (CREDIT_W+1)'(1);
      2'b01:   coin_val = (CREDIT_W+1)'(2);
      2'b10:   coin_val = (CREDIT_W+1)'(5);
      default: coin_val = (CREDIT_W+1)'(10);
    endcase
  endfunction

  assign coin_sum   = {1'b0, credit_q} + coin_val(coin);
  assign sel_price  = price_of(product);
  assign vend_price = price_of(prod_q);
  assign prod_ok    = int'(product) < NUM_PROD;
  assign vend_ok    = prod_ok && stock_ok && (credit_q >= sel_price);

`ifdef VEND_STOCK_EN
  localparam int STOCK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
  logic [NUM_PROD-1:0] empty_vec;

  for (genvar i = 0; i < NUM_PROD; i++) begin : g_stock
    vend_stock_cnt #(.W(STOCK_W), .INIT(STOCK_INIT)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .dec   (state_q == VEND && prod_q == PSEL_W'(i)),
      .empty (empty_vec[i])
    );
  end

  always_comb begin
    stock_ok = 1'b0;
    for (int i = 0; i < NUM_PROD; i++)
      if (product == PSEL_W'(i)) stock_ok = !empty_vec[i];
  end

  assign sold_out = empty_vec;
`else
  assign stock_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      prod_q   <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      prod_q   <= prod_d;
      reject_q <= reject_d;
    end
  end

  // Strobes only matter in IDLE/COLLECT; busy states run to completion regardless of enable.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    prod_d   = prod_q;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && coin_insert) begin
          if (coin_sum[CREDIT_W]) reject_d = 1'b1;
          else begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (enable) begin
          if (coin_return) state_d = CHANGE;
          else if (vend_req) begin
            if (vend_ok) begin
              prod_d  = product;
              state_d = VEND;
            end else reject_d = 1'b1;
          end else if (coin_insert) begin
            if (coin_sum[CREDIT_W]) reject_d = 1'b1;
            else                    credit_d = coin_sum[CREDIT_W-1:0];
          end
        end
      end
      VEND: begin
        credit_d = credit_q - vend_price;
        state_d  = (credit_q != vend_price) ? CHANGE : IDLE;
      end
      CHANGE: begin
        credit_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q == VEND) || (state_q == CHANGE);
  assign pro_valid    = (state_q == VEND);
  assign pro          = prod_q;
  assign change_valid = (state_q == CHANGE);
  assign change       = change_valid ? credit_q : '0;
  assign credit       = credit_q;
  assign reject       = reject_q;
endmodule

// File: tb/tb_vending_controller_param.sv
// Bench for vending_controller_param: directed scenarios then random strobes,
// checked every cycle against a transaction-level model of credit and scheduled payouts.
module tb_vending_controller_param;
  logic       clk = 1'b0;
  logic       reset = 1'b1, enable = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       coin_insert = 1'b0, coin_return = 1'b0, vend_req = 1'b0;
  logic [1:0] product = 2'b00;
  logic [1:0] pro;
  logic       pro_valid, change_valid, reject, busy;
  logic [4:0] change, credit;
`ifdef VEND_STOCK_EN
  logic [3:0] sold_out;
`endif

  vending_controller_param dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .coin         (coin),
    .coin_insert  (coin_insert),
    .coin_return  (coin_return),
    .product      (product),
    .vend_req     (vend_req),
    .pro          (pro),
    .pro_valid    (pro_valid),
    .change       (change),
    .change_valid (change_valid),
    .credit       (credit),
    .reject       (reject),
    .busy         (busy)
`ifdef VEND_STOCK_EN
    ,
    .sold_out     (sold_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pv; int pro; bit cv; int chg; int cr; bit rej; bit bsy;
  } exp_t;

  int   errors = 0, checks = 0;
  int   prices[4] = '{5, 10, 15, 20};
  int   coin_units[4] = '{1, 2, 5, 10};
  int   m_credit = 0;
  int   m_stock[4] = '{3, 3, 3, 3};
  exp_t cur;
  exp_t sched[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Model: credit is a number; an accepted vend/return queues the busy cycles it will produce.
  task automatic step(input bit r, input bit en, input logic [1:0] c, input bit ins,
                      input bit ret, input logic [1:0] p, input bit vr);
    exp_t nx;
    @(negedge clk);
    reset = r; enable = en; coin = c; coin_insert = ins;
    coin_return = ret; product = p; vend_req = vr;
    nx = '{default: 0};
    if (r) begin
      sched.delete();
      m_credit = 0;
      foreach (m_stock[i]) m_stock[i] = 3;
    end else if (cur.bsy) begin
      if (sched.size() > 0) nx = sched.pop_front();
    end else if (en) begin
      if (m_credit > 0 && ret) begin
        nx = '{pv: 0, pro: 0, cv: 1, chg: m_credit, cr: m_credit, rej: 0, bsy: 1};
        m_credit = 0;
      end else if (m_credit > 0 && vr) begin
        bit ok;
        ok = m_credit >= prices[p];
`ifdef VEND_STOCK_EN
        ok = ok && m_stock[p] > 0;
`endif
        if (ok) begin
          int rem;
          rem = m_credit - prices[p];
          nx = '{pv: 1, pro: p, cv: 0, chg: 0, cr: m_credit, rej: 0, bsy: 1};
          if (rem > 0) sched.push_back('{pv: 0, pro: 0, cv: 1, chg: rem, cr: rem, rej: 0, bsy: 1});
          m_credit = 0;
          m_stock[p]--;
        end else nx.rej = 1;
      end else if (ins) begin
        if (m_credit + coin_units[c] > 31) nx.rej = 1;
        else m_credit += coin_units[c];
      end
    end
    if (!nx.bsy) nx.cr = m_credit;
    cur = nx;
    @(posedge clk);
    #1;
    chk("pro_valid", 32'(pro_valid), 32'(cur.pv));
    if (cur.pv) chk("pro", 32'(pro), 32'(cur.pro));
    chk("change_valid", 32'(change_valid), 32'(cur.cv));
    chk("change", 32'(change), 32'(cur.chg));
    chk("credit", 32'(credit), 32'(cur.cr));
    chk("reject", 32'(reject), 32'(cur.rej));
    chk("busy", 32'(busy), 32'(cur.bsy));
`ifdef VEND_STOCK_EN
    for (int i = 0; i < 4; i++) chk("sold_out", 32'(sold_out[i]), 32'(m_stock[i] == 0));
`endif
  endtask

  task automatic do_reset();               step(1, 0, 2'b00, 0, 0, 2'd0, 0); endtask
  task automatic idle();                   step(0, 1, 2'b00, 0, 0, 2'd0, 0); endtask
  task automatic put(input logic [1:0] c); step(0, 1, c, 1, 0, 2'd0, 0); endtask
  task automatic buy(input logic [1:0] p); step(0, 1, 2'b00, 0, 0, p, 1); endtask
  task automatic refund();                 step(0, 1, 2'b00, 0, 1, 2'd0, 0); endtask

  initial begin
    cur = '{default: 0};
    do_reset();
    do_reset();

    // 10 units, buy product 1 exactly
    put(2'b11); buy(2'd1); idle(); idle();
    // 15 units, buy product 0, change 10
    put(2'b11); put(2'b10); buy(2'd0); idle(); idle();
    // 2 units, product 3 refused, then refund
    put(2'b01); buy(2'd3); idle(); refund(); idle();
    // 30 units, overflowing coin refused, return beats vend
    put(2'b11); put(2'b11); put(2'b11); put(2'b01);
    step(0, 1, 2'b00, 0, 1, 2'd0, 1); idle(); idle();
    // four 5-unit purchases of product 0 (stock limits the last under the macro)
    do_reset();
    repeat (4) begin put(2'b10); buy(2'd0); idle(); idle(); end
    refund(); idle();
    // reset discards credit 7
    put(2'b10); put(2'b01); step(1, 1, 2'b00, 1, 1, 2'd0, 1); idle();
    // enable low ignores strobes; busy ignores strobes; IDLE ignores vend/return
    step(0, 0, 2'b11, 1, 0, 2'd0, 0);
    step(0, 1, 2'b00, 0, 1, 2'd0, 1);
    put(2'b11); put(2'b11); buy(2'd2);
    step(0, 0, 2'b11, 1, 1, 2'd0, 1);
    step(0, 1, 2'b11, 1, 1, 2'd0, 1);
    idle();
    // coin in IDLE alongside vend/return still counts
    step(0, 1, 2'b10, 1, 1, 2'd0, 1); refund(); idle();

    for (int n = 0; n < 800; n++) begin
      bit r, en, ins, ret, vr;
      r   = ($urandom % 80) == 0;
      en  = ($urandom % 8) != 0;
      ins = ($urandom % 2) == 0;
      ret = ($urandom % 12) == 0;
      vr  = ($urandom % 5) == 0;
      step(r, en, 2'($urandom), ins, ret, 2'($urandom), vr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
